// File: rtl/mem_access_pkg.sv
// Shared types for the memory-access stage: access-size encodings, FSM states
// and the byte-lane count helper.
package mem_access_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } mem_size_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Byte lanes in a DATA_W-wide datapath.
    function automatic int lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-data extraction: shifts the addressed field down from a full-width read
// and sign- or zero-extends it to DATA_W.
module mem_load_align
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFFW   = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [OFFW-1:0]   offset,
    input  mem_size_e         size,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] load_data
);

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic              sbit;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        mask    = '1;
        sbit    = shifted[DATA_W-1];
        case (size)
            SZ_B: begin mask = DATA_W'(8'hFF);         sbit = shifted[7];  end
            SZ_H: begin mask = DATA_W'(16'hFFFF);      sbit = shifted[15]; end
            SZ_W: begin mask = DATA_W'(32'hFFFF_FFFF); sbit = shifted[31]; end
            default: ;
        endcase
        // With a full-width mask ~mask is zero, so dword needs no special case.
        load_data = (shifted & mask) | ((!is_unsigned && sbit) ? ~mask : '0);
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage plus MEM/WB register with sub-word access and a req/ack data-memory port.
// Define MISALIGN_CHK_EN to trap misaligned accesses instead of force-aligning them.
module mem_access_stage
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int REG_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic [DATA_W-1:0]   store_data,
    input  logic [REG_W-1:0]    dst_reg,
    input  logic                reg_write,
    input  logic                wb_sel,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [1:0]          mem_size,
    input  logic                mem_unsigned,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [ADDR_W-1:0]   dmem_addr,
    output logic [DATA_W-1:0]   dmem_wdata,
    output logic [DATA_W/8-1:0] dmem_be,
    input  logic                dmem_ack,
    input  logic [DATA_W-1:0]   dmem_rdata,
    output logic                wb_valid,
    output logic [DATA_W-1:0]   wb_data,
    output logic [REG_W-1:0]    wb_dst,
    output logic                wb_reg_write
`ifdef MISALIGN_CHK_EN
   ,output logic                misalign
`endif
);

    localparam int LANES = lanes(DATA_W);
    localparam int OFFW  = $clog2(LANES);

    state_e              state_q, state_d;
    logic                req_q, req_d, we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LANES-1:0]    be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    mem_size_e           sz_q, sz_d;
    logic                uns_q, uns_d, wbsel_q, wbsel_d, regw_q, regw_d;
    logic [DATA_W-1:0]   alu_q, alu_d;
    logic [REG_W-1:0]    dst_q, dst_d;
    logic                wb_valid_q, wb_valid_d, wb_regw_q, wb_regw_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic [REG_W-1:0]    wb_dst_q, wb_dst_d;
    logic                misalign_q, misalign_d;

    mem_size_e           sz_eff;
    logic [ADDR_W-1:0]   addr_in, align_mask, addr_al;
    logic [LANES-1:0]    be_base;
    logic [DATA_W-1:0]   wdata_rep;
    logic [DATA_W-1:0]   load_ext;
    logic                is_mem, misaligned;

    // Request decode from the EX-side operands.
    always_comb begin
        sz_eff = mem_size_e'(mem_size);
        if (DATA_W == 32 && sz_eff == SZ_D) sz_eff = SZ_W;
        addr_in = alu_result[ADDR_W-1:0];
        case (sz_eff)
            SZ_B: begin align_mask = '0;            be_base = LANES'(1);     wdata_rep = {LANES{store_data[7:0]}}; end
            SZ_H: begin align_mask = ADDR_W'(1);    be_base = LANES'(2'h3);  wdata_rep = {(LANES/2){store_data[15:0]}}; end
            SZ_W: begin align_mask = ADDR_W'(3);    be_base = LANES'(4'hF);  wdata_rep = {(DATA_W/32){store_data[31:0]}}; end
            default: begin align_mask = ADDR_W'(7); be_base = '1;            wdata_rep = store_data; end
        endcase
        misaligned = |(addr_in & align_mask);
        addr_al    = addr_in & ~align_mask;
        is_mem     = mem_read | mem_write;
    end

    mem_load_align #(.DATA_W(DATA_W), .OFFW(OFFW)) u_load_align (
        .rdata       (dmem_rdata),
        .offset      (addr_q[OFFW-1:0]),
        .size        (sz_q),
        .is_unsigned (uns_q),
        .load_data   (load_ext)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        sz_d       = sz_q;
        uns_d      = uns_q;
        wbsel_d    = wbsel_q;
        alu_d      = alu_q;
        dst_d      = dst_q;
        regw_d     = regw_q;
        wb_valid_d = 1'b0;
        wb_regw_d  = 1'b0;
        misalign_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_dst_d   = wb_dst_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (!is_mem) begin
                        wb_valid_d = 1'b1;
                        wb_regw_d  = reg_write;
                        wb_data_d  = alu_result;
                        wb_dst_d   = dst_reg;
`ifdef MISALIGN_CHK_EN
                    end else if (misaligned) begin
                        wb_valid_d = 1'b1;
                        wb_dst_d   = dst_reg;
                        misalign_d = 1'b1;
`endif
                    end else begin
                        state_d = BUSY;
                        req_d   = 1'b1;
                        we_d    = mem_write;
                        addr_d  = addr_al;
                        be_d    = be_base << addr_al[OFFW-1:0];
                        wdata_d = wdata_rep;
                        sz_d    = sz_eff;
                        uns_d   = mem_unsigned;
                        wbsel_d = wb_sel;
                        alu_d   = alu_result;
                        dst_d   = dst_reg;
                        regw_d  = reg_write;
                    end
                end
            end
            default: begin
                if (dmem_ack && req_q) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_regw_d  = regw_q;
                    wb_data_d  = wbsel_q ? load_ext : alu_q;
                    wb_dst_d   = dst_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            sz_q       <= SZ_B;
            uns_q      <= 1'b0;
            wbsel_q    <= 1'b0;
            alu_q      <= '0;
            dst_q      <= '0;
            regw_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_regw_q  <= 1'b0;
            wb_data_q  <= '0;
            wb_dst_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            sz_q       <= sz_d;
            uns_q      <= uns_d;
            wbsel_q    <= wbsel_d;
            alu_q      <= alu_d;
            dst_q      <= dst_d;
            regw_q     <= regw_d;
            wb_valid_q <= wb_valid_d;
            wb_regw_q  <= wb_regw_d;
            wb_data_q  <= wb_data_d;
            wb_dst_q   <= wb_dst_d;
            misalign_q <= misalign_d;
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_be      = be_q;
    assign dmem_wdata   = wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_data      = wb_data_q;
    assign wb_dst       = wb_dst_q;
    assign wb_reg_write = wb_regw_q;
`ifdef MISALIGN_CHK_EN
    assign misalign     = misalign_q;
`else
    // Without the checker there is nothing to report; keep the unused flops tied off.
    logic unused_misalign;
    assign unused_misalign = misalign_q ^ misaligned;
`endif

endmodule
